// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU op encodings, bus widths and sequencer state encoding.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 4;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  // Not an ALU encoding: the sequencer expands it into repeated ADDs.
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_if / alu_bus_if
// Brief    : Request/response handshake channel and the ALU operand/result bus.
// Revision : 1.0
// ============================================================================
interface alu_req_if import alu_pkg::*; #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CTRL_W = alu_pkg::CTRL_W
);
  logic              ReqValid;
  logic              ReqReady;
  logic [CTRL_W-1:0] ReqOp;
  logic [DATA_W-1:0] ReqA;
  logic [DATA_W-1:0] ReqB;
  logic              RspValid;
  logic              RspReady;
  logic [DATA_W-1:0] RspData;
  logic              RspZero;

  modport master (
    output ReqValid, ReqOp, ReqA, ReqB, RspReady,
    input  ReqReady, RspValid, RspData, RspZero
  );

  modport slave (
    input  ReqValid, ReqOp, ReqA, ReqB, RspReady,
    output ReqReady, RspValid, RspData, RspZero
  );
endinterface

interface alu_bus_if import alu_pkg::*; #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CTRL_W = alu_pkg::CTRL_W
);
  logic [CTRL_W-1:0] ALUCtrl;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;
  logic [DATA_W-1:0] BusW;
  logic              Zero;

  modport master (
    output ALUCtrl, BusA, BusB,
    input  BusW, Zero
  );

  modport slave (
    input  ALUCtrl, BusA, BusB,
    output BusW, Zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Brief    : Shift-add multiply state; each step feeds one ADD through the ALU.
// Revision : 1.0
// ============================================================================
module alu_mul_iter import alu_pkg::*; #(
  parameter int DATA_W    = alu_pkg::DATA_W,
  parameter int MUL_ITERS = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  input  logic [DATA_W-1:0] bus_w,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic              done
);

  localparam int              CNT_W    = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = bus_w;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // No early exit on a zero multiplier, so the latency never depends on data.
  always_comb begin
    bus_a = acc_q;
    bus_b = mplier_q[0] ? mcand_q : '0;
    done  = step && (cnt_q == LAST_CNT);
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Handshaked front end driving a combinational ALU, with MUL built
//            from repeated ALU ADDs.
// Revision : 1.0
// ============================================================================
module alu_sequencer import alu_pkg::*; #(
  parameter int DATA_W    = alu_pkg::DATA_W,
  parameter int CTRL_W    = alu_pkg::CTRL_W,
  parameter int MUL_ITERS = DATA_W
) (
  input  logic       CLK,
  input  logic       Resetl,
  alu_req_if.slave   req,
  alu_bus_if.master  alu
);

  seq_state_e        state_q, state_d;
  logic [CTRL_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_bus_a;
  logic [DATA_W-1:0] mul_bus_b;

  assign accept    = (state_q == ST_IDLE) && req.ReqValid;
  assign mul_start = accept && (req.ReqOp == CTRL_W'(ALU_MUL));

  alu_mul_iter #(
    .DATA_W    (DATA_W),
    .MUL_ITERS (MUL_ITERS)
  ) u_mul (
    .clk      (CLK),
    .rst_n    (Resetl),
    .start    (mul_start),
    .step     (state_q == ST_MUL),
    .mcand_i  (req.ReqA),
    .mplier_i (req.ReqB),
    .bus_w    (alu.BusW),
    .bus_a    (mul_bus_a),
    .bus_b    (mul_bus_b),
    .done     (mul_done)
  );

  always_ff @(posedge CLK or negedge Resetl) begin
    if (!Resetl) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req.ReqValid) state_d = mul_start ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_MUL:  if (mul_done) state_d = ST_RESP;
      ST_RESP: if (req.RspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The MUL zero flag is derived from the final sum itself, since the ALU's
  // Zero reflects the same value only by coincidence of the ADD encoding.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    if (accept) begin
      op_d = req.ReqOp;
      a_d  = req.ReqA;
      b_d  = req.ReqB;
    end
    if (state_q == ST_EXEC) begin
      rsp_data_d = alu.BusW;
      rsp_zero_d = alu.Zero;
    end else if (mul_done) begin
      rsp_data_d = alu.BusW;
      rsp_zero_d = (alu.BusW == '0);
    end
  end

  // ALU buses depend only on state and registers, never directly on Req*.
  always_comb begin
    req.ReqReady = (state_q == ST_IDLE);
    req.RspValid = (state_q == ST_RESP);
    req.RspData  = rsp_data_q;
    req.RspZero  = rsp_zero_q;
    alu.ALUCtrl  = '0;
    alu.BusA     = '0;
    alu.BusB     = '0;
    case (state_q)
      ST_EXEC: begin
        alu.ALUCtrl = op_q;
        alu.BusA    = a_q;
        alu.BusB    = b_q;
      end
      ST_MUL: begin
        alu.ALUCtrl = CTRL_W'(ALU_ADD);
        alu.BusA    = mul_bus_a;
        alu.BusB    = mul_bus_b;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
